// File: rtl/mod_seq.sv
// Multi-cycle unsigned restoring divider. It runs UNROLL iterations per clock
// and gives a single-cycle done pulse. A zero divisor completes one cycle after it is accepted.
module mod_seq #(
    parameter int WIDTH  = 19,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] n,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] ITERS = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] STEP  = CNT_W'(UNROLL);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] res_q, res_d;

    logic [WIDTH:0]   rem_it;
    logic [WIDTH-1:0] dvd_it;
    logic             last;

    // One restoring step. The dividend register shifts left, and each new quotient
    // bit enters at its LSB, so the register holds the quotient once all WIDTH steps are done.
    function automatic logic [2*WIDTH:0] div_step(input logic [WIDTH:0]   rem,
                                                  input logic [WIDTH-1:0] dvd,
                                                  input logic [WIDTH-1:0] dsr);
        logic        [WIDTH+1:0] sh;
        logic signed [WIDTH+1:0] diff;
        sh   = {rem, dvd[WIDTH-1]};
        diff = $signed(sh) - $signed({2'b00, dsr});
        if (diff[WIDTH+1])
            return {sh[WIDTH:0], dvd[WIDTH-2:0], 1'b0};
        else
            return {diff[WIDTH:0], dvd[WIDTH-2:0], 1'b1};
    endfunction

    always_comb begin
        rem_it = rem_q;
        dvd_it = dvd_q;
        for (int i = 0; i < UNROLL; i++) begin
            if (CNT_W'(i) < cnt_q)
                {rem_it, dvd_it} = div_step(rem_it, dvd_it, dsr_q);
        end
        last = (cnt_q <= STEP);
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        quo_d   = quo_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = a;
                    dsr_d   = n;
                    rem_d   = '0;
                    cnt_d   = ITERS;
                    zero_d  = (n == '0);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (zero_q) begin
                    quo_d   = '1;
                    res_d   = dvd_q;
                    dz_d    = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    dvd_d = dvd_it;
                    rem_d = rem_it;
                    if (last) begin
                        cnt_d   = '0;
                        quo_d   = dvd_it;
                        res_d   = rem_it[WIDTH-1:0];
                        dz_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - STEP;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            quo_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
        end
    end

    // The divisor is only read while BUSY, after a load, so it needs no reset.
    always_ff @(posedge clk) begin
        dsr_q <= dsr_d;
    end

    assign ready    = (state_q == IDLE);
    assign done     = done_q;
    assign q        = quo_q;
    assign r        = res_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_mod_seq.sv
// Bench for mod_seq: three instances (UNROLL = 1, 4, 19) share one clock and reset;
// results are checked against per-instance queues of expected quotient/remainder/latency.
module tb_mod_seq;

    typedef struct {
        logic [18:0] q;
        logic [18:0] r;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s1 = 1'b0, s4 = 1'b0, s19 = 1'b0;
    logic [18:0] a1 = '0, n1 = '0, a4 = '0, n4 = '0, a19 = '0, n19 = '0;
    logic rdy1, rdy4, rdy19, done1, done4, done19, dz1, dz4, dz19;
    logic [18:0] q1, r1, q4, r4, q19, r19;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t sb1[$], sb4[$], sb19[$];
    exp_t m1, m4, m19;

    mod_seq #(.WIDTH(19), .UNROLL(1)) u1 (
        .clk(clk), .rst(rst), .start(s1), .a(a1), .n(n1),
        .ready(rdy1), .done(done1), .q(q1), .r(r1), .div_zero(dz1));
    mod_seq #(.WIDTH(19), .UNROLL(4)) u4 (
        .clk(clk), .rst(rst), .start(s4), .a(a4), .n(n4),
        .ready(rdy4), .done(done4), .q(q4), .r(r4), .div_zero(dz4));
    mod_seq #(.WIDTH(19), .UNROLL(19)) u19 (
        .clk(clk), .rst(rst), .start(s19), .a(a19), .n(n19),
        .ready(rdy19), .done(done19), .q(q19), .r(r19), .div_zero(dz19));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (done1 === 1'b1) begin
            checks++;
            if (sb1.size() == 0) begin
                errors++;
                $display("FAIL u1_unexpected_done q=%0d r=%0d required no done pulse", q1, r1);
            end else begin
                m1 = sb1.pop_front();
                if ({q1, r1, dz1} !== {m1.q, m1.r, m1.dz}) begin
                    errors++;
                    $display("FAIL u1_result q=%0d r=%0d dz=%b required q=%0d r=%0d dz=%b",
                             q1, r1, dz1, m1.q, m1.r, m1.dz);
                end
                checks++;
                if (cyc - m1.acc != m1.lat) begin
                    errors++;
                    $display("FAIL u1_latency got %0d required %0d", cyc - m1.acc, m1.lat);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (done4 === 1'b1) begin
            checks++;
            if (sb4.size() == 0) begin
                errors++;
                $display("FAIL u4_unexpected_done q=%0d r=%0d required no done pulse", q4, r4);
            end else begin
                m4 = sb4.pop_front();
                if ({q4, r4, dz4} !== {m4.q, m4.r, m4.dz}) begin
                    errors++;
                    $display("FAIL u4_result q=%0d r=%0d dz=%b required q=%0d r=%0d dz=%b",
                             q4, r4, dz4, m4.q, m4.r, m4.dz);
                end
                checks++;
                if (cyc - m4.acc != m4.lat) begin
                    errors++;
                    $display("FAIL u4_latency got %0d required %0d", cyc - m4.acc, m4.lat);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (done19 === 1'b1) begin
            checks++;
            if (sb19.size() == 0) begin
                errors++;
                $display("FAIL u19_unexpected_done q=%0d r=%0d required no done pulse", q19, r19);
            end else begin
                m19 = sb19.pop_front();
                if ({q19, r19, dz19} !== {m19.q, m19.r, m19.dz}) begin
                    errors++;
                    $display("FAIL u19_result q=%0d r=%0d dz=%b required q=%0d r=%0d dz=%b",
                             q19, r19, dz19, m19.q, m19.r, m19.dz);
                end
                checks++;
                if (cyc - m19.acc != m19.lat) begin
                    errors++;
                    $display("FAIL u19_latency got %0d required %0d", cyc - m19.acc, m19.lat);
                end
            end
        end
    end

    function automatic logic rdy_of(input int d);
        case (d)
            1:       return rdy1;
            4:       return rdy4;
            default: return rdy19;
        endcase
    endfunction

    function automatic int lat_of(input int d);
        case (d)
            1:       return 19;
            4:       return 5;
            default: return 1;
        endcase
    endfunction

    // Waits (bounded) for ready, drives one accepted start, records the expectation.
    task automatic issue(input int d, input logic [18:0] av, input logic [18:0] nv, input bit push);
        int   t = 0;
        exp_t e;
        while (rdy_of(d) !== 1'b1 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (rdy_of(d) !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL u%0d_ready_timeout ready=%b required 1", d, rdy_of(d));
        end
        case (d)
            1:       begin s1  = 1'b1; a1  = av; n1  = nv; end
            4:       begin s4  = 1'b1; a4  = av; n4  = nv; end
            default: begin s19 = 1'b1; a19 = av; n19 = nv; end
        endcase
        @(posedge clk); #1;
        e.q   = (nv == 0) ? 19'h7FFFF : av / nv;
        e.r   = (nv == 0) ? av : av % nv;
        e.dz  = (nv == 0);
        e.lat = (nv == 0) ? 1 : lat_of(d);
        e.acc = cyc;
        if (push) begin
            case (d)
                1:       sb1.push_back(e);
                4:       sb4.push_back(e);
                default: sb19.push_back(e);
            endcase
        end
        case (d)
            1:       s1  = 1'b0;
            4:       s4  = 1'b0;
            default: s19 = 1'b0;
        endcase
    endtask

    task automatic wait_done1(input string tag);
        int t = 0;
        do begin
            @(posedge clk); #1; t++;
        end while (done1 !== 1'b1 && t < 100);
        if (done1 !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout done=%b required 1 within 100 cycles", tag, done1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s1 = 1'b1; a1 = 19'd5; n1 = 19'd1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rdy1, done1, q1, r1, dz1} !== {1'b1, 1'b0, 19'd0, 19'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_u1 ready=%b done=%b q=%0d r=%0d dz=%b required 1 0 0 0 0",
                     rdy1, done1, q1, r1, dz1);
        end
        checks++;
        if ({rdy4, rdy19, done4, done19, q4, q19} !== {1'b1, 1'b1, 1'b0, 1'b0, 19'd0, 19'd0}) begin
            errors++;
            $display("FAIL reset_others ready=%b%b done=%b%b q=%0d/%0d required 11 00 0/0",
                     rdy4, rdy19, done4, done19, q4, q19);
        end
        rst = 1'b0;
        s1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_priority ready=%b required 1 (start under reset must be ignored)", rdy1);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        issue(1, 19'd100, 19'd7, 1'b1);
        checks++;
        if (rdy1 !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy ready=%b required 0", rdy1);
        end
        wait_done1("basic");
    endtask

    task automatic test_boundaries();
        logic [18:0] av[3] = '{19'd524287, 19'd5, 19'd0};
        logic [18:0] nv[3] = '{19'd1,      19'd9, 19'd3};
        for (int i = 0; i < 3; i++) begin
            issue(1, av[i], nv[i], 1'b1);
            wait_done1("boundary");
        end
    endtask

    task automatic test_div_zero();
        issue(1, 19'd1234, 19'd0, 1'b1);
        wait_done1("divzero");
        issue(1, 19'd10, 19'd3, 1'b1);
        wait_done1("after_divzero");
    endtask

    task automatic test_back_to_back();
        issue(1, 19'd200, 19'd9, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        s1 = 1'b1; a1 = 19'd77; n1 = 19'd5;
        @(posedge clk); #1;
        s1 = 1'b0; a1 = 19'd4000; n1 = 19'd2;
        checks++;
        if (rdy1 !== 1'b0) begin
            errors++;
            $display("FAIL midbusy_ready ready=%b required 0", rdy1);
        end
        wait_done1("midbusy");
        issue(1, 19'd1000, 19'd13, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({q1, r1} !== {19'd22, 19'd2}) begin
            errors++;
            $display("FAIL hold_during_busy q=%0d r=%0d required q=22 r=2", q1, r1);
        end
        wait_done1("back_to_back");
    endtask

    task automatic test_reset_busy();
        bit seen = 1'b0;
        issue(1, 19'd300, 19'd7, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({rdy1, done1, q1, r1, dz1} !== {1'b1, 1'b0, 19'd0, 19'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_busy ready=%b done=%b q=%0d r=%0d dz=%b required 1 0 0 0 0",
                     rdy1, done1, q1, r1, dz1);
        end
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done1 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_busy_no_done done pulse seen=1 required 0");
        end
    endtask

    task automatic test_random(input int d);
        logic [18:0] av, nv;
        int sel;
        for (int i = 0; i < 10000; i++) begin
            av  = 19'($urandom_range(0, 524287));
            sel = int'($urandom_range(0, 15));
            if (sel == 0)      nv = 19'd0;
            else if (sel < 5)  nv = 19'($urandom_range(1, 31));
            else               nv = 19'($urandom_range(1, 524287));
            issue(d, av, nv, 1'b1);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((sb1.size() + sb4.size() + sb19.size()) != 0 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if ((sb1.size() + sb4.size() + sb19.size()) != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required 0", sb1.size() + sb4.size() + sb19.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_back_to_back();
        test_reset_busy();
        fork
            test_random(4);
            test_random(19);
        join
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_seq.md
MOD_SEQ -- requirements
Module: mod_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 19, operand/result width in bits (legal 2..64).
REQ-002 SHALL have parameter UNROLL, default 1, restoring-division iterations performed per clock (legal 1..WIDTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a division; accepted only when ready=1.
REQ-006 SHALL have port a  input  WIDTH  dividend, unsigned, sampled on accepted start.
REQ-007 SHALL have port n  input  WIDTH  divisor, unsigned, sampled on accepted start.
REQ-008 SHALL have port ready  output  1  high when the block can accept start.
REQ-009 SHALL have port done  output  1  single-cycle pulse; q, r, div_zero valid from this cycle.
REQ-010 SHALL have port q  output  WIDTH  quotient floor(a/n).
REQ-011 SHALL have port r  output  WIDTH  remainder a mod n.
REQ-012 SHALL have port div_zero  output  1  high with done when the sampled n was 0.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (ready=1) and BUSY (ready=0).
REQ-014 SHALL, on an edge with start=1 in IDLE, latch a and n, clear the partial remainder (WIDTH+1 bits), and enter BUSY; start=1 in BUSY SHALL be ignored.
REQ-015 SHALL, per iteration, shift the dividend MSB into the partial remainder, trial-subtract n, keep the difference and shift in quotient bit 1 if non-negative, else restore and shift in 0.
REQ-016 SHALL perform UNROLL iterations per BUSY edge, fewer on the final edge, totalling exactly WIDTH iterations over L = ceil(WIDTH/UNROLL) edges.
REQ-017 SHALL, on acceptance at edge k with n!=0, update q and r and return to IDLE at edge k+L, asserting done for the cycle following edge k+L only.
REQ-018 SHALL, when the sampled n=0, skip iteration, set q=all ones, r=a, div_zero=1 at edge k+1, and pulse done in the following cycle.
REQ-019 SHALL clear div_zero on every non-zero-divisor completion.
REQ-020 SHALL hold q, r, div_zero at their last completed values during BUSY and IDLE until the next completion.
REQ-021 SHALL, for n!=0, guarantee a = q*n + r and r < n for all WIDTH-bit unsigned inputs, including n > a (q=0, r=a) and a=0 (q=0, r=0).
REQ-022 SHALL allow back-to-back operation: start asserted in the done cycle (ready=1) is accepted, and the next result follows after latency L.
REQ-023 SHALL not depend on a or n after the accepting edge; input changes during BUSY have no effect.

Reset
REQ-024 SHALL, on an edge with rst=1, force IDLE, ready=1, done=0, q=0, r=0, div_zero=0, and clear internal dividend/remainder/iteration counter.
REQ-025 SHALL give rst priority over start on the same edge; start is not accepted.
REQ-026 SHALL, when rst asserts during BUSY, abandon the operation with no done pulse and no change to q/r other than the reset values.

Verification
REQ-027 SHALL cover WIDTH=19, UNROLL=1: a=100, n=7 -> done 19 cycles after accepting edge, q=14, r=2, div_zero=0.
REQ-028 SHALL cover boundaries: a=524287, n=1 -> q=524287, r=0; a=5, n=9 -> q=0, r=5; a=0, n=3 -> q=0, r=0.
REQ-029 SHALL cover a=1234, n=0 -> done 1 cycle after acceptance, q=524287, r=1234, div_zero=1; the next divide 10/3 -> q=3, r=1, div_zero=0.
REQ-030 SHALL cover start pulsed mid-BUSY with different a/n -> ignored, original result unchanged; start in done cycle -> second result exactly L cycles later.
REQ-031 SHALL cover rst asserted at cycle 8 of a 19-cycle divide -> no done pulse, all outputs at reset values, ready=1 next cycle.
REQ-032 SHALL cover WIDTH=19, UNROLL=4 (L=5) and UNROLL=19 (L=1) with 10000 random operands checked against a reference model for q, r and latency.
